// File: rtl/vga_timing_pkg.sv
// Shared timing constants and lock-FSM state type for the VGA sync decoder.
// Holds the 640x480@60 reference timing (800x525 totals, 640x480 visible,
// 96-clock hsync, 2-line vsync) plus the counter widths used by the decoder.
package vga_timing_pkg;

  localparam int H_TOTAL_DEF  = 800;
  localparam int V_TOTAL_DEF  = 525;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int H_SYNC_W     = 96;
  localparam int V_SYNC_W     = 2;

  localparam int CNT_W = 10;
  localparam int ACC_W = 19;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

endpackage

// File: rtl/sync_period_counter.sv
// Falling-edge detector plus saturating period counter for one sync signal.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sync_n     : already-registered active-low sync
//   tick       : count enable (every clock for h, every line start for v)
//   start      : falling edge of sync_n this cycle
//   err        : start seen with a measured period other than TOTAL
module sync_period_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = 800
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_n,
  input  logic tick,
  output logic start,
  output logic err
);

  logic             sync_d_p1;
  logic [CNT_W-1:0] period_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign start = sync_d_p1 & ~sync_n;
  // The compare uses the count before the restart, so a coincident tick on
  // the start cycle belongs to the new period.
  assign err   = start & (period_p1 != CNT_W'(TOTAL));

  // ---- stage p1: edge history and period count ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d_p1 <= 1'b0;
      period_p1 <= '0;
    end else begin
      sync_d_p1 <= sync_n;
      if (start)
        period_p1 <= tick ? CNT_W'(1) : '0;
      else if (tick)
        period_p1 <= sat_inc(period_p1);
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from a VGA sync/blank stream, tracks timing lock
// and counts lit red/green pixels per frame.
// Ports:
//   VGA_clk, rst_n          : pixel clock, asynchronous active-low reset
//   VGA_hSync, VGA_vSync    : active-low syncs
//   blank_n                 : high inside the visible area
//   pix_r, pix_g, pix_b     : colour channel MSBs
//   px_x, px_y, px_valid    : recovered coordinates, two clocks after the pixel
//   frame_done              : pulse when red_cnt/green_cnt update
//   locked, timing_err      : lock status, pulse on loss of lock
//   red_cnt, green_cnt      : lit-pixel counts of the last complete locked frame
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic             VGA_clk,
  input  logic             rst_n,
  input  logic             VGA_hSync,
  input  logic             VGA_vSync,
  input  logic             blank_n,
  input  logic             pix_r,
  input  logic             pix_g,
  input  logic             pix_b,
  output logic [CNT_W-1:0] px_x,
  output logic [CNT_W-1:0] px_y,
  output logic             px_valid,
  output logic             frame_done,
  output logic             locked,
  output logic             timing_err,
  output logic [ACC_W-1:0] red_cnt,
  output logic [ACC_W-1:0] green_cnt
);

  lock_state_e state, state_nxt;

  logic hs_p0, vs_p0, blank_p0, r_p0, g_p0;
  logic blank_p1;
  logic line_start, line_err, frame_start, frame_err;
  logic blank_rise, blank_fall;
  logic h_act_err, v_act_err, vs_act_err, any_err;
  logic meas_err;
  logic [CNT_W-1:0] act_cnt_p1, act_lines_p1, x_run_p1, y_run_p1, x_cur;
  logic [ACC_W-1:0] red_acc, green_acc, red_sum, green_sum;

  // Blue has no counter; it is part of the pixel interface only.
  logic unused_pix_b;
  assign unused_pix_b = pix_b;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic             inc);
    return (a == {ACC_W{1'b1}}) ? a : a + ACC_W'(inc);
  endfunction

  // ---- stage p0: input registers ----
  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_p0    <= 1'b0;
      vs_p0    <= 1'b0;
      blank_p0 <= 1'b0;
      r_p0     <= 1'b0;
      g_p0     <= 1'b0;
    end else begin
      hs_p0    <= VGA_hSync;
      vs_p0    <= VGA_vSync;
      blank_p0 <= blank_n;
      r_p0     <= pix_r;
      g_p0     <= pix_g;
    end
  end

  sync_period_counter #(.TOTAL(H_TOTAL)) u_h_period (
    .clk    (VGA_clk),
    .rst_n  (rst_n),
    .sync_n (hs_p0),
    .tick   (1'b1),
    .start  (line_start),
    .err    (line_err)
  );

  sync_period_counter #(.TOTAL(V_TOTAL)) u_v_period (
    .clk    (VGA_clk),
    .rst_n  (rst_n),
    .sync_n (vs_p0),
    .tick   (line_start),
    .start  (frame_start),
    .err    (frame_err)
  );

  assign blank_rise = blank_p0 & ~blank_p1;
  assign blank_fall = ~blank_p0 & blank_p1;

  // An active cycle beyond H_ACTIVE, an active line beyond V_ACTIVE, or any
  // active cycle during vertical sync breaks the expected raster.
  assign h_act_err  = blank_p0 & ~line_start & (act_cnt_p1 >= CNT_W'(H_ACTIVE));
  assign v_act_err  = blank_rise & ~frame_start & (act_lines_p1 >= CNT_W'(V_ACTIVE));
  assign vs_act_err = blank_p0 & ~vs_p0;
  assign any_err    = line_err | frame_err | h_act_err | v_act_err | vs_act_err;

  assign locked = (state == LOCKED);

  assign x_cur     = blank_rise ? '0 : sat_inc(x_run_p1);
  // The pixel on the frame-start cycle still belongs to the closing frame.
  assign red_sum   = acc_add(red_acc,   blank_p0 & r_p0);
  assign green_sum = acc_add(green_acc, blank_p0 & g_p0);

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (frame_start) state_nxt = MEASURE;
      MEASURE: if (frame_start && !meas_err && !any_err) state_nxt = LOCKED;
      LOCKED:  if (any_err) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  // ---- stage p1: lock state, raster tracking, accumulation, outputs ----
  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      meas_err   <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      timing_err <= locked & any_err;
      // Each frame start opens a fresh measurement window.
      if (frame_start)
        meas_err <= 1'b0;
      else if (any_err)
        meas_err <= 1'b1;
    end
  end

  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_p1     <= 1'b0;
      act_cnt_p1   <= '0;
      act_lines_p1 <= '0;
      x_run_p1     <= '0;
      y_run_p1     <= '0;
      px_x         <= '0;
      px_y         <= '0;
      px_valid     <= 1'b0;
      red_acc      <= '0;
      green_acc    <= '0;
      red_cnt      <= '0;
      green_cnt    <= '0;
      frame_done   <= 1'b0;
    end else begin
      blank_p1 <= blank_p0;

      if (line_start)
        act_cnt_p1 <= blank_p0 ? CNT_W'(1) : '0;
      else if (blank_p0)
        act_cnt_p1 <= sat_inc(act_cnt_p1);

      if (frame_start)
        act_lines_p1 <= blank_rise ? CNT_W'(1) : '0;
      else if (blank_rise)
        act_lines_p1 <= sat_inc(act_lines_p1);

      if (blank_p0)
        x_run_p1 <= x_cur;

      if (frame_start)
        y_run_p1 <= '0;
      else if (blank_fall)
        y_run_p1 <= sat_inc(y_run_p1);

      px_valid <= blank_p0 & locked;
      if (blank_p0 && locked) begin
        px_x <= x_cur;
        px_y <= y_run_p1;
      end

      frame_done <= frame_start & locked;
      if (frame_start) begin
        red_acc   <= '0;
        green_acc <= '0;
        if (locked) begin
          red_cnt   <= red_sum;
          green_cnt <= green_sum;
        end
      end else begin
        red_acc   <= red_sum;
        green_acc <= green_sum;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced 40x24 raster
// (20x12 visible) so that every scenario fits in a short run.
// Horizontal: hsync low h=0..3, visible h=10..29, total 40.
// Vertical:   vsync low lines 0..1, visible lines 5..16, total 24.
// Full-red frame = 20*12 = 240 lit pixels; green square 3x3 at (5,4) = 9.
module tb_vga_sync_decoder;

  localparam int HT = 40;
  localparam int VT = 24;
  localparam int HA = 20;
  localparam int VA = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs = 1'b1, vs = 1'b1, bl = 1'b0, pr = 1'b0, pg = 1'b0, pb = 1'b0;
  logic [9:0]  px_x, px_y;
  logic        px_valid, frame_done, locked, timing_err;
  logic [18:0] red_cnt, green_cnt;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .VGA_clk    (clk),
    .rst_n      (rst_n),
    .VGA_hSync  (hs),
    .VGA_vSync  (vs),
    .blank_n    (bl),
    .pix_r      (pr),
    .pix_g      (pg),
    .pix_b      (pb),
    .px_x       (px_x),
    .px_y       (px_y),
    .px_valid   (px_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .timing_err (timing_err),
    .red_cnt    (red_cnt),
    .green_cnt  (green_cnt)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [19:0] pix_q[$];
  logic [37:0] done_q[$];
  logic [19:0] pe;
  logic [37:0] de;
  bit          px_chk = 1'b1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expected coordinates / frame counts as the DUT presents them.
  always @(negedge clk) begin
    if (px_valid && px_chk) begin
      if (pix_q.size() == 0) chk("px_valid unexpected", 1, 0);
      else begin
        pe = pix_q.pop_front();
        chk("px_x", px_x, pe[19:10]);
        chk("px_y", px_y, pe[9:0]);
      end
    end
    if (frame_done) begin
      if (done_q.size() == 0) chk("frame_done unexpected", 1, 0);
      else begin
        de = done_q.pop_front();
        chk("red_cnt", red_cnt, de[37:19]);
        chk("green_cnt", green_cnt, de[18:0]);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, " px_x"}, px_x, 0);
    chk({tag, " px_y"}, px_y, 0);
    chk({tag, " px_valid"}, px_valid, 0);
    chk({tag, " frame_done"}, frame_done, 0);
    chk({tag, " locked"}, locked, 0);
    chk({tag, " timing_err"}, timing_err, 0);
    chk({tag, " red_cnt"}, red_cnt, 0);
    chk({tag, " green_cnt"}, green_cnt, 0);
  endtask

  // pix_mode: 0 = no px_valid allowed, 1 = every visible pixel expected valid,
  // 2 = px_valid not checked (lock changes mid-frame).
  task automatic run_frame(input string tag, input bit red_all, input bit sq,
                           input int pix_mode, input bit lk_before, input bit lk_after,
                           input int stretch_line, input bit vs_blank,
                           input int te_exp_pos, input bit lk_end, input int rst_at);
    int c = 0;
    int te_cnt = 0;
    int te_pos = -1;
    int rst_rel = -1;
    bit lk_prev;
    lk_prev = locked;
    px_chk = (pix_mode != 2);
    for (int l = 0; l < VT; l++) begin
      int len;
      len = HT + ((l == stretch_line) ? 1 : 0);
      for (int h = 0; h < len; h++) begin
        bit act_l, act_h, act;
        act_l = (l >= 5) && (l < 17);
        act_h = (h >= 10) && (h < 30);
        act   = act_l && act_h;
        hs = !(h < 4);
        vs = !(l < 2);
        bl = act || (vs_blank && l == 0 && act_h);
        pr = act && red_all;
        pg = act && sq && (h - 10) >= 5 && (h - 10) < 8 && (l - 5) >= 4 && (l - 5) < 7;
        if (act && pix_mode == 1) pix_q.push_back({10'(h - 10), 10'(l - 5)});
        if (c == rst_rel) rst_n = 1'b1;
        if (c == rst_at) begin
          #1 rst_n = 1'b0;
          #1 check_all_zero({tag, " async reset"});
          rst_rel = c + 3;
        end
        @(negedge clk);
        if (c == 1) chk({tag, " locked at start+1"}, locked, lk_before);
        if (c == 2) chk({tag, " locked at start+2"}, locked, lk_after);
        if (timing_err) begin
          te_cnt++;
          te_pos = c;
          chk({tag, " locked with timing_err"}, locked, 0);
          chk({tag, " locked before timing_err"}, lk_prev, 1);
        end
        lk_prev = locked;
        @(posedge clk);
        #1;
        c++;
      end
    end
    chk({tag, " timing_err pulses"}, te_cnt, (te_exp_pos < 0) ? 0 : 1);
    if (te_exp_pos >= 0) chk({tag, " timing_err position"}, te_pos, te_exp_pos);
    chk({tag, " locked at frame end"}, locked, lk_end);
  endtask

  task automatic push_done(input int r, input int g);
    done_q.push_back({19'(r), 19'(g)});
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end

    // Lock acquisition: MEASURE at first frame start, LOCKED at second.
    run_frame("f1", 0, 0, 0, 0, 0, -1, 0, -1, 0, -1);
    run_frame("f2", 1, 0, 1, 0, 1, -1, 0, -1, 1, -1);
    push_done(240, 0);
    run_frame("f3", 0, 1, 1, 1, 1, -1, 0, -1, 1, -1);
    push_done(0, 9);
    run_frame("f4", 1, 1, 1, 1, 1, -1, 0, -1, 1, -1);
    push_done(240, 9);
    // Line 7 lasts 41 clocks: line 8 starts at c=321, error pulse at c=323.
    run_frame("f5", 0, 0, 2, 1, 1, 7, 0, 323, 0, -1);
    run_frame("f6", 0, 0, 0, 0, 0, -1, 0, -1, 0, -1);
    chk("red_cnt held out of lock", red_cnt, 240);
    chk("green_cnt held out of lock", green_cnt, 9);
    run_frame("f7", 1, 0, 1, 0, 1, -1, 0, -1, 1, -1);
    push_done(240, 0);
    // blank_n high at c=10 while vsync low: error pulse at c=12.
    run_frame("f8", 0, 0, 2, 1, 1, -1, 1, 12, 0, -1);
    run_frame("f9", 0, 0, 0, 0, 0, -1, 0, -1, 0, -1);
    chk("red_cnt held after vsync error", red_cnt, 240);
    chk("green_cnt held after vsync error", green_cnt, 0);
    run_frame("f10", 1, 0, 1, 0, 1, -1, 0, -1, 1, -1);
    push_done(240, 0);
    // Reset mid-line 8 (c=335), then re-lock one clean frame after the
    // first post-reset frame start.
    run_frame("f11", 0, 0, 2, 1, 1, -1, 0, -1, 0, 335);
    run_frame("f12", 0, 0, 0, 0, 0, -1, 0, -1, 0, -1);
    run_frame("f13", 0, 0, 1, 0, 1, -1, 0, -1, 1, -1);

    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("red_cnt after reset re-lock", red_cnt, 0);
    chk("green_cnt after reset re-lock", green_cnt, 0);
    chk("pixel queue drained", pix_q.size(), 0);
    chk("frame_done queue drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
